// File: rtl/cmd_parse_multi_pkg.sv
// Shared definitions for the multi-channel command parser: response codes,
// FSM state encoding, command characters and a constant-width helper.
package cmd_parse_multi_pkg;

  // Response type codes driven on send_resp_type
  localparam logic [1:0] RESP_OK   = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;
  localparam logic [1:0] RESP_DATA = 2'b10;

  // Parser FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GET_CH    = 2'd1,
    ST_GET_ARG   = 2'd2,
    ST_SEND_RESP = 2'd3
  } state_t;

  // Command letters (7-bit ASCII, bit 7 of the received byte is ignored)
  localparam logic [6:0] CHAR_W_UC = 7'h57;
  localparam logic [6:0] CHAR_W_LC = 7'h77;
  localparam logic [6:0] CHAR_R_UC = 7'h52;
  localparam logic [6:0] CHAR_R_LC = 7'h72;

  // Number of bits needed to hold values 0..value-1 (ceil(log2(value))).
  // Callers clamp the result to at least 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_parse_multi_hex_char_decode.sv
// Combinational ASCII hex digit decoder: {invalid, value[3:0]}.
module hex_char_decode (
  input  logic [6:0] char_in,
  output logic [4:0] dec_out
);

  // Map 0-9, A-F, a-f to 0..15; anything else flags invalid with value 0
  always_comb begin
    dec_out = 5'b1_0000;
    if (char_in >= 7'h30 && char_in <= 7'h39) begin
      dec_out = {1'b0, 4'(char_in - 7'h30)};
    end else if (char_in >= 7'h41 && char_in <= 7'h46) begin
      dec_out = {1'b0, 4'(char_in - 7'h37)};
    end else if (char_in >= 7'h61 && char_in <= 7'h66) begin
      dec_out = {1'b0, 4'(char_in - 7'h57)};
    end
  end

endmodule

// File: rtl/cmd_parse_multi.sv
// Character command parser: W<ch><hex digits> writes a channel register,
// R<ch> reads one back. Every accepted character is echoed, and each
// command ends in an OK / ERR / DATA response held until send_resp_done.
//
// Handshake: a character is taken only on the first cycle rx_data_rdy is
// seen high while char_fifo_full is low; a response is offered by holding
// send_resp_val (with stable type/data) until send_resp_done is sampled
// high, at which point val drops and the parser returns to IDLE.
module cmd_parse_multi
  import cmd_parse_multi_pkg::*;
#(
  parameter int ARG_DIGITS = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                           clk_rx,
  input  logic                           rst_clk_rx_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_data_rdy,
  input  logic                           char_fifo_full,
  output logic                           send_char_val,
  output logic [7:0]                     send_char,
  output logic                           send_resp_val,
  output logic [1:0]                     send_resp_type,
  output logic [4*ARG_DIGITS-1:0]        send_resp_data,
  input  logic                           send_resp_done,
  output logic [NUM_CH*4*ARG_DIGITS-1:0] ch_data,
  output logic [NUM_CH-1:0]              ch_wr_stb,
  output logic [1:0]                     state_dbg
);

  localparam int DATA_W = 4 * ARG_DIGITS;
  localparam int CNT_W  = (clogb2(ARG_DIGITS) < 1) ? 1 : clogb2(ARG_DIGITS);
  localparam int CH_W   = (clogb2(NUM_CH) < 1) ? 1 : clogb2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ARG_DIGITS - 1);

  state_t                     state_q, state_d;
  logic                       rdy_prev_q, rdy_prev_d;
  logic                       is_write_q, is_write_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]          shift_q, shift_d;
  logic                       char_val_q, char_val_d;
  logic [7:0]                 char_q, char_d;
  logic                       resp_val_q, resp_val_d;
  logic [1:0]                 resp_type_q, resp_type_d;
  logic [DATA_W-1:0]          resp_data_q, resp_data_d;
  logic [NUM_CH*DATA_W-1:0]   ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]          stb_q, stb_d;

  logic [4:0]        dec;
  logic              dec_bad;
  logic [3:0]        dec_val;
  logic              accept;
  logic              ch_ok;
  logic              is_w_cmd;
  logic              is_r_cmd;
  logic [DATA_W-1:0] shift_next;

  hex_char_decode u_hex_char_decode (
    .char_in (rx_data[6:0]),
    .dec_out (dec)
  );

  assign dec_bad    = dec[4];
  assign dec_val    = dec[3:0];
  assign accept     = rx_data_rdy & ~rdy_prev_q & ~char_fifo_full;
  assign ch_ok      = !dec_bad && (int'(dec_val) < NUM_CH);
  assign is_w_cmd   = (rx_data[6:0] == CHAR_W_UC) || (rx_data[6:0] == CHAR_W_LC);
  assign is_r_cmd   = (rx_data[6:0] == CHAR_R_UC) || (rx_data[6:0] == CHAR_R_LC);
  // New digit enters at the LSB nibble; the oldest nibble falls off the top
  assign shift_next = DATA_W'({shift_q, dec_val});

  // Next-state, echo, argument accumulation and response generation
  always_comb begin
    state_d     = state_q;
    rdy_prev_d  = rx_data_rdy;
    is_write_d  = is_write_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    char_val_d  = accept;
    char_d      = accept ? rx_data : char_q;
    resp_val_d  = resp_val_q;
    resp_type_d = resp_type_q;
    resp_data_d = resp_data_q;
    ch_data_d   = ch_data_q;
    stb_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_w_cmd) begin
            is_write_d = 1'b1;
            state_d    = ST_GET_CH;
          end else if (is_r_cmd) begin
            is_write_d = 1'b0;
            state_d    = ST_GET_CH;
          end
        end
      end

      ST_GET_CH: begin
        if (accept) begin
          if (!ch_ok) begin
            resp_val_d  = 1'b1;
            resp_type_d = RESP_ERR;
            state_d     = ST_SEND_RESP;
          end else if (is_write_q) begin
            ch_d    = CH_W'(dec_val);
            shift_d = '0;
            cnt_d   = CNT_LOAD;
            state_d = ST_GET_ARG;
          end else begin
            ch_d        = CH_W'(dec_val);
            resp_val_d  = 1'b1;
            resp_type_d = RESP_DATA;
            for (int k = 0; k < NUM_CH; k++) begin
              if (int'(dec_val) == k) resp_data_d = ch_data_q[k*DATA_W +: DATA_W];
            end
            state_d = ST_SEND_RESP;
          end
        end
      end

      ST_GET_ARG: begin
        if (accept) begin
          if (dec_bad) begin
            resp_val_d  = 1'b1;
            resp_type_d = RESP_ERR;
            state_d     = ST_SEND_RESP;
          end else begin
            shift_d = shift_next;
            if (cnt_q == '0) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (int'(ch_q) == k) begin
                  ch_data_d[k*DATA_W +: DATA_W] = shift_next;
                  stb_d[k] = 1'b1;
                end
              end
              resp_val_d  = 1'b1;
              resp_type_d = RESP_OK;
              state_d     = ST_SEND_RESP;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
      end

      ST_SEND_RESP: begin
        // Characters here are echoed only; the response stays put until done
        if (send_resp_done) begin
          resp_val_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      state_q     <= ST_IDLE;
      rdy_prev_q  <= 1'b0;
      is_write_q  <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      char_val_q  <= 1'b0;
      char_q      <= 8'h00;
      resp_val_q  <= 1'b0;
      resp_type_q <= RESP_ERR;
      resp_data_q <= '0;
      ch_data_q   <= '0;
      stb_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_prev_q  <= rdy_prev_d;
      is_write_q  <= is_write_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      char_val_q  <= char_val_d;
      char_q      <= char_d;
      resp_val_q  <= resp_val_d;
      resp_type_q <= resp_type_d;
      resp_data_q <= resp_data_d;
      ch_data_q   <= ch_data_d;
      stb_q       <= stb_d;
    end
  end

  assign send_char_val  = char_val_q;
  assign send_char      = char_q;
  assign send_resp_val  = resp_val_q;
  assign send_resp_type = resp_type_q;
  assign send_resp_data = resp_data_q;
  assign ch_data        = ch_data_q;
  assign ch_wr_stb      = stb_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_cmd_parse_multi.sv
// Bench for cmd_parse_multi: directed command strings plus randomized
// commands, checked against a string-level model of the command set.
`timescale 1ns/1ps
module tb_cmd_parse_multi;

  localparam int ARG_DIGITS = 8;
  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 4 * ARG_DIGITS;
  localparam logic [1:0] T_OK   = 2'b00;
  localparam logic [1:0] T_ERR  = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk_rx = 1'b0;
  logic                     rst_clk_rx_n = 1'b1;
  logic [7:0]               rx_data = 8'h00;
  logic                     rx_data_rdy = 1'b0;
  logic                     char_fifo_full = 1'b0;
  logic                     send_char_val;
  logic [7:0]               send_char;
  logic                     send_resp_val;
  logic [1:0]               send_resp_type;
  logic [DATA_W-1:0]        send_resp_data;
  logic                     send_resp_done = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_wr_stb;
  logic [1:0]               state_dbg;

  always #5 clk_rx = ~clk_rx;

  cmd_parse_multi #(.ARG_DIGITS(ARG_DIGITS), .NUM_CH(NUM_CH)) dut (
    .clk_rx         (clk_rx),
    .rst_clk_rx_n   (rst_clk_rx_n),
    .rx_data        (rx_data),
    .rx_data_rdy    (rx_data_rdy),
    .char_fifo_full (char_fifo_full),
    .send_char_val  (send_char_val),
    .send_char      (send_char),
    .send_resp_val  (send_resp_val),
    .send_resp_type (send_resp_type),
    .send_resp_data (send_resp_data),
    .send_resp_done (send_resp_done),
    .ch_data        (ch_data),
    .ch_wr_stb      (ch_wr_stb),
    .state_dbg      (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [7:0]        exp_q[$];        // expected echoes
  logic [1:0]        rtype_q[$];      // expected response types
  logic [DATA_W-1:0] rdata_q[$];      // expected response data
  int                wr_ch_q[$];      // expected register writes
  logic [DATA_W-1:0] m_ch [NUM_CH];
  logic [6:0]        m_cmd[$];        // characters of the command in progress
  bit                m_busy;          // a response is outstanding

  function automatic int hex_of(input logic [6:0] c);
    if (c >= 7'h30 && c <= 7'h39) return int'(c) - 48;
    if (c >= 7'h41 && c <= 7'h46) return int'(c) - 55;
    if (c >= 7'h61 && c <= 7'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] model_vec();
    logic [NUM_CH*DATA_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*DATA_W +: DATA_W] = m_ch[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_ch[k] = '0;
    m_cmd.delete();
    m_busy = 1'b0;
  endtask

  task automatic model_resp(input logic [1:0] t, input logic [DATA_W-1:0] d);
    rtype_q.push_back(t);
    rdata_q.push_back(d);
    m_busy = 1'b1;
    m_cmd.delete();
  endtask

  // Apply one accepted character to the command-set reference model
  task automatic model_char(input logic [7:0] ch);
    logic [6:0]        c;
    int                idx;
    logic [DATA_W-1:0] val;
    c = ch[6:0];
    exp_q.push_back(ch);
    if (m_busy) return;
    if (m_cmd.size() == 0) begin
      if (c == 7'h57 || c == 7'h77 || c == 7'h52 || c == 7'h72) m_cmd.push_back(c);
      return;
    end
    m_cmd.push_back(c);
    idx = hex_of(m_cmd[1]);
    if (m_cmd.size() == 2) begin
      if (idx < 0 || idx >= NUM_CH) model_resp(T_ERR, '0);
      else if (m_cmd[0] == 7'h52 || m_cmd[0] == 7'h72) model_resp(T_DATA, m_ch[idx]);
      return;
    end
    if (hex_of(c) < 0) begin
      model_resp(T_ERR, '0);
      return;
    end
    if (m_cmd.size() == 2 + ARG_DIGITS) begin
      val = '0;
      for (int i = 2; i < 2 + ARG_DIGITS; i++) val = (val << 4) | DATA_W'(hex_of(m_cmd[i]));
      m_ch[idx] = val;
      wr_ch_q.push_back(idx);
      model_resp(T_OK, '0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_rx) begin
    logic [7:0] e;
    int         wc;
    if (rst_clk_rx_n) begin
      if (send_char_val === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL echo_unexpected got=%h required=none", send_char);
        end else begin
          e = exp_q.pop_front();
          if (send_char !== e) begin
            failures++;
            $display("FAIL echo_char got=%h required=%h", send_char, e);
          end
        end
      end
      if (ch_wr_stb !== '0) begin
        checks++;
        if (wr_ch_q.size() == 0) begin
          failures++;
          $display("FAIL wr_stb_unexpected got=%b required=0000", ch_wr_stb);
        end else begin
          wc = wr_ch_q.pop_front();
          if (ch_wr_stb !== NUM_CH'(1 << wc) || ch_data !== model_vec()) begin
            failures++;
            $display("FAIL wr_stb got_stb=%b got_data=%h required_stb=%b required_data=%h",
                     ch_wr_stb, ch_data, NUM_CH'(1 << wc), model_vec());
          end
        end
      end
      if (send_resp_val === 1'b1) begin
        checks++;
        if (!m_busy) begin
          failures++;
          $display("FAIL resp_spurious got_val=1 required_val=0 type=%b", send_resp_type);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_char_t(input logic [7:0] c, input int hold, input bit full_first);
    @(posedge clk_rx); #1;
    rx_data        = c;
    rx_data_rdy    = 1'b1;
    char_fifo_full = full_first;
    if (!full_first) model_char(c);
    @(posedge clk_rx); #1;
    char_fifo_full = 1'b0;
    repeat (hold - 1) @(posedge clk_rx);
    #1;
    rx_data_rdy = 1'b0;
    @(posedge clk_rx); #1;
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_char_t(s[i], hold, 1'b0);
  endtask

  // Wait for the response, check it and its stability, then complete it
  task automatic finish_resp(input int delay);
    int                n;
    logic [1:0]        et, ct;
    logic [DATA_W-1:0] ed, cd;
    n = 0;
    while (send_resp_val !== 1'b1 && n < 100) begin
      @(posedge clk_rx); #1;
      n++;
    end
    checks++;
    if (send_resp_val !== 1'b1) begin
      failures++;
      $display("FAIL resp_timeout got_val=%b required_val=1", send_resp_val);
      return;
    end
    checks++;
    if (rtype_q.size() == 0) begin
      failures++;
      $display("FAIL resp_unexpected got_type=%b required=none", send_resp_type);
    end else begin
      et = rtype_q.pop_front();
      ed = rdata_q.pop_front();
      if (send_resp_type !== et) begin
        failures++;
        $display("FAIL resp_type got=%b required=%b", send_resp_type, et);
      end
      if (et == T_DATA) begin
        checks++;
        if (send_resp_data !== ed) begin
          failures++;
          $display("FAIL resp_data got=%h required=%h", send_resp_data, ed);
        end
      end
    end
    ct = send_resp_type;
    cd = send_resp_data;
    repeat (delay) begin
      @(posedge clk_rx); #1;
    end
    checks++;
    if (send_resp_val !== 1'b1 || send_resp_type !== ct || send_resp_data !== cd) begin
      failures++;
      $display("FAIL resp_hold got=%b/%b/%h required=1/%b/%h",
               send_resp_val, send_resp_type, send_resp_data, ct, cd);
    end
    send_resp_done = 1'b1;
    @(posedge clk_rx); #1;
    send_resp_done = 1'b0;
    m_busy = 1'b0;
    checks++;
    if (send_resp_val !== 1'b0) begin
      failures++;
      $display("FAIL resp_clear got_val=%b required_val=0", send_resp_val);
    end
  endtask

  task automatic check_regs(input string tag);
    checks++;
    if (ch_data !== model_vec() || exp_q.size() != 0 || wr_ch_q.size() != 0) begin
      failures++;
      $display("FAIL regs_%s got=%h required=%h pending_echo=%0d pending_wr=%0d",
               tag, ch_data, model_vec(), exp_q.size(), wr_ch_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (send_char_val !== 1'b0 || send_char !== 8'h00 || send_resp_val !== 1'b0 ||
        send_resp_type !== T_ERR || send_resp_data !== '0 || ch_data !== '0 || ch_wr_stb !== '0) begin
      failures++;
      $display("FAIL reset_%s got=%b/%h/%b/%b/%h/%h/%b required=0/00/0/01/0/0/0", tag,
               send_char_val, send_char, send_resp_val, send_resp_type, send_resp_data,
               ch_data, ch_wr_stb);
    end
  endtask

  function automatic logic [7:0] hex_char(input int nib, input bit upper);
    if (nib < 10) return 8'(8'h30 + nib);
    return upper ? 8'(8'h41 + nib - 10) : 8'(8'h61 + nib - 10);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    #2 rst_clk_rx_n = 1'b0;
    #1 check_reset_outputs("initial");
    repeat (3) @(posedge clk_rx);
    #1 rst_clk_rx_n = 1'b1;
    @(posedge clk_rx); #1;
    check_reset_outputs("after_release");
  endtask

  task automatic test_write();
    send_str("W212345678", 16);
    finish_resp(3);
    check_regs("write");
    checks++;
    if (ch_data[95:64] !== 32'h12345678) begin
      failures++;
      $display("FAIL write_ch2 got=%h required=12345678", ch_data[95:64]);
    end
  endtask

  task automatic test_read();
    send_str("r2", 16);
    finish_resp(10);
    check_regs("read");
  endtask

  task automatic test_fifo_full();
    send_str("W1", 16);
    send_char_t("9", 16, 1'b1);          // dropped: FIFO full on its rising edge
    send_str("89ABCDEF", 16);
    finish_resp(2);
    check_regs("fifo_full");
    checks++;
    if (ch_data[63:32] !== 32'h89ABCDEF) begin
      failures++;
      $display("FAIL fifo_full_ch1 got=%h required=89abcdef", ch_data[63:32]);
    end
  endtask

  task automatic test_errors();
    send_str("W5", 16);
    finish_resp(1);
    send_str("W1ab#", 16);
    finish_resp(1);
    check_regs("bad_arg");
    // done while idle must be ignored
    send_resp_done = 1'b1;
    @(posedge clk_rx); #1;
    send_resp_done = 1'b0;
    send_str("Q", 16);
    repeat (3) @(posedge clk_rx);
    #1;
    checks++;
    if (send_resp_val !== 1'b0) begin
      failures++;
      $display("FAIL echo_only got_val=%b required_val=0", send_resp_val);
    end
    send_str("R1", 4);
    finish_resp(0);
    check_regs("errors");
  endtask

  task automatic test_reset_mid();
    send_str("W0ABC", 16);
    #2 rst_clk_rx_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("mid_command");
    repeat (2) @(posedge clk_rx);
    #1 rst_clk_rx_n = 1'b1;
    send_str("R0", 16);
    finish_resp(2);
    check_regs("after_mid_reset");
  endtask

  task automatic test_busy();
    send_str("W3deadBEEF", 16);
    send_str("R0", 16);                  // echoed while the OK is pending
    finish_resp(20);
    repeat (5) @(posedge clk_rx);
    #1;
    checks++;
    if (send_resp_val !== 1'b0 || ch_data[127:96] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL busy got_val=%b got_ch3=%h required=0/deadbeef",
               send_resp_val, ch_data[127:96]);
    end
    check_regs("busy");
  endtask

  task automatic test_random();
    logic [7:0] cmd[$];
    logic [7:0] c;
    for (int n = 0; n < 25; n++) begin
      cmd.delete();
      case ($urandom_range(0, 3))
        0: cmd.push_back(8'h57);
        1: cmd.push_back(8'h77);
        2: cmd.push_back(8'h52);
        default: cmd.push_back(8'h72);
      endcase
      if ($urandom_range(0, 9) == 0) cmd.push_back(8'h23);
      else cmd.push_back(hex_char($urandom_range(0, 5), 1'b1));
      if (cmd[0] == 8'h57 || cmd[0] == 8'h77) begin
        for (int i = 0; i < ARG_DIGITS; i++) begin
          if ($urandom_range(0, 15) == 0) cmd.push_back(($urandom_range(0, 1) == 0) ? 8'h57 : 8'h78);
          else cmd.push_back(hex_char($urandom_range(0, 15), $urandom_range(0, 1) == 1));
        end
      end
      foreach (cmd[i]) begin
        c = cmd[i];
        if ($urandom_range(0, 3) == 0) c[7] = 1'b1;
        send_char_t(c, $urandom_range(2, 6), $urandom_range(0, 15) == 0);
        if (m_busy) finish_resp($urandom_range(0, 4));
      end
    end
    check_regs("random");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_errors();
    test_reset_mid();
    test_busy();
    test_random();
    repeat (4) @(posedge clk_rx);
    #1;
    checks++;
    if (exp_q.size() != 0 || rtype_q.size() != 0 || wr_ch_q.size() != 0) begin
      failures++;
      $display("FAIL final_queues got=%0d/%0d/%0d required=0/0/0",
               exp_q.size(), rtype_q.size(), wr_ch_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cmd_parse_multi.md
CMD_PARSE_MULTI -- requirements
Module: cmd_parse_multi

Interface
REQ-001 SHALL provide parameter ARG_DIGITS, default 8, number of hex digits in a write argument (range 1..8).
REQ-002 SHALL provide parameter NUM_CH, default 4, number of target data registers (range 1..16).
REQ-003 SHALL derive localparam DATA_W = 4*ARG_DIGITS, the register width in bits.
REQ-004 clk_rx  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_clk_rx_n  input  1  reset, asynchronous assert, active low.
REQ-006 rx_data  input  8  received character; bit 7 ignored.
REQ-007 rx_data_rdy  input  1  character valid; held high for several clocks.
REQ-008 char_fifo_full  input  1  echo FIFO full.
REQ-009 send_char_val  output  1  one-cycle echo strobe.
REQ-010 send_char  output  8  echoed character.
REQ-011 send_resp_val  output  1  response request, held until done.
REQ-012 send_resp_type  output  2  00 OK, 01 ERR, 10 DATA.
REQ-013 send_resp_data  output  DATA_W  payload for DATA responses.
REQ-014 send_resp_done  input  1  response generator finished.
REQ-015 ch_data  output  NUM_CH*DATA_W  flattened registers; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-016 ch_wr_stb  output  NUM_CH  one-hot, one-cycle pulse on the cycle a channel register updates.

Function
REQ-017 A new character SHALL be accepted only on the first cycle rx_data_rdy is high (rising edge versus the registered previous value) with char_fifo_full low; any other character is dropped entirely and is not echoed or parsed.
REQ-018 Each accepted character SHALL be echoed: send_char = rx_data and send_char_val = 1 on the following cycle; this applies in every state.
REQ-019 Hex decode SHALL accept 0-9, A-F and a-f, giving values 0-15; every other character is non-hex.
REQ-020 The FSM SHALL have the states IDLE, GET_CH, GET_ARG and SEND_RESP.
REQ-021 IDLE: 'W'/'w' SHALL set op=WRITE and 'R'/'r' SHALL set op=READ, each moving to GET_CH; every other character is ignored.
REQ-022 GET_CH: a hex digit below NUM_CH SHALL latch the channel; a non-hex digit or a digit >= NUM_CH SHALL raise ERR.
REQ-023 GET_CH, READ: a valid channel SHALL issue DATA with send_resp_data = that channel's register and go to SEND_RESP.
REQ-024 GET_CH, WRITE: a valid channel SHALL clear the shift register, load the digit counter with ARG_DIGITS-1, and go to GET_ARG.
REQ-025 GET_ARG: each hex digit SHALL shift in at the LSB nibble, MSB-first order.
REQ-026 GET_ARG: on the ARG_DIGITS-th digit, the channel register SHALL load the full value, the matching ch_wr_stb bit SHALL pulse in the same cycle the register updates, and an OK response SHALL be issued.
REQ-027 GET_ARG: a non-hex character, including 'W' or 'R', SHALL raise ERR and leave the channel register unchanged.
REQ-028 Raising a response SHALL set send_resp_val = 1 and send_resp_type in the cycle after the triggering character, and SHALL enter SEND_RESP.
REQ-029 SEND_RESP: send_resp_val, send_resp_type and send_resp_data SHALL hold until send_resp_done = 1, then send_resp_val SHALL clear and the FSM SHALL return to IDLE in the same cycle.
REQ-030 Characters accepted in SEND_RESP SHALL be echoed but not parsed; send_resp_done outside SEND_RESP SHALL be ignored.
REQ-031 Registers SHALL only change on a completed write; a READ response SHALL capture the register value at the request cycle.
REQ-032 Undefined state encodings SHALL return to IDLE on the next clock.

Reset
REQ-033 Reset SHALL asynchronously force state = IDLE, previous-rdy = 0, send_char_val = 0, send_char = 00h, send_resp_val = 0, send_resp_type = ERR, send_resp_data = 0, ch_data = 0, ch_wr_stb = 0, and clear the counter and shift register.
REQ-034 Reset asserted mid-command SHALL abort the command with no register update and no response; after release the block SHALL wait in IDLE for a new command letter.

Structure
REQ-035 A shared package SHALL hold the response-type codes, state encodings and command character constants (W, w, R, r).
REQ-036 Hex decoding SHALL be a separate combinational sub-module, hex_char_decode, with a 7-bit character in and a {invalid, value[3:0]} result out.
REQ-037 The digit counter width SHALL be clogb2(ARG_DIGITS) bits, with a minimum of 1.

Verification (NUM_CH=4, ARG_DIGITS=8)
REQ-038 Send "W212345678", then done -> ch_data[95:64] = 12345678h, ch_wr_stb = 0100b for one cycle, OK response, 10 echoes.
REQ-039 After REQ-038, send "r2" -> DATA response with send_resp_data = 12345678h, held until done.
REQ-040 Send "W5" -> ERR response; "W1ab#" -> ERR with channel 1 unchanged; "Q" in IDLE -> echo only.
REQ-041 Hold rx_data_rdy high for 16 cycles per character, and keep char_fifo_full high during one rising edge -> that character is neither echoed nor parsed; every other character is processed exactly once.
REQ-042 Assert rst_clk_rx_n low after "W0ABC" -> all outputs reach their reset values without a clock edge; a following "R0" -> DATA 00000000h.
REQ-043 Send "W3deadBEEF", withhold done for 50 cycles while sending "R0" -> send_resp_val held, "R0" echoed but not parsed, ch_data[127:96] = DEADBEEFh.
